// File: rtl/handball_pkg.sv
// rtl/handball_pkg.sv - shared constants, state and action types for the handball sequencer
package handball_pkg;

  // Shift register mode commands
  localparam logic [1:0] SH_HOLD = 2'b00;
  localparam logic [1:0] SH_R    = 2'b01;  // toward LSB (ball travels to the wall)
  localparam logic [1:0] SH_L    = 2'b10;  // toward MSB (ball returns to the player)
  localparam logic [1:0] SH_LOAD = 2'b11;

  // LED patterns for parallel load
  localparam logic [7:0] PAT_SERVE = 8'h80;
  localparam logic [7:0] PAT_BLANK = 8'h00;
  localparam logic [7:0] PAT_OVER  = 8'hFF;

  // Step period counter width; holds the default 12.5M divider
  localparam int PER_W = 24;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_OUT,
    ST_BACK,
    ST_MISS,
    ST_OVER
  } state_t;

  // What the FSM decided to do this cycle; the output process turns it into datapath updates
  typedef enum logic [2:0] {
    ACT_NONE,
    ACT_START,
    ACT_SERVE,
    ACT_SHR,
    ACT_SHL,
    ACT_HIT,
    ACT_MISS,
    ACT_WAIT
  } act_t;

endpackage

// File: rtl/handball_if.sv
// rtl/handball_if.sv - button inputs and shift-register / score outputs of the sequencer
interface handball_if #(
  parameter int SCORE_W = 4
);
  logic               START;
  logic               PULSER;
  logic [1:0]         S;
  logic [7:0]         LGIN;
  logic [SCORE_W-1:0] SCORE;
  logic [2:0]         LIVES_LEFT;
  logic               GAME_OVER;

  // Player / board side: drives buttons, observes the game
  modport master (
    output START, PULSER,
    input  S, LGIN, SCORE, LIVES_LEFT, GAME_OVER
  );

  // Sequencer side
  modport slave (
    input  START, PULSER,
    output S, LGIN, SCORE, LIVES_LEFT, GAME_OVER
  );
endinterface

// File: rtl/handball_tick.sv
// rtl/handball_tick.sv - programmable-period tick generator with synchronous clear
module handball_tick
  import handball_pkg::*;
#(
  parameter int W    = PER_W,
  parameter int INIT = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_clr,
  input  logic [W-1:0] i_period,
  output logic         o_tick
);

  logic [W-1:0] r_cnt;
  logic [W-1:0] r_period;

  // The period is only sampled when the count restarts, so a change never shortens a step in flight
  assign o_tick = (r_cnt == r_period - W'(1));

  // Count 0..period-1, restarting on wrap or on an explicit clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_period <= W'(INIT);
    end else if (i_clr || o_tick) begin
      r_cnt    <= '0;
      r_period <= i_period;
    end else begin
      r_cnt    <= r_cnt + W'(1);
    end
  end

endmodule

// File: rtl/handball_ctrl.sv
// rtl/handball_ctrl.sv - handball game sequencer driving the Bidshift LED shift register
module handball_ctrl
  import handball_pkg::*;
#(
  parameter int TICK_DIV   = 12_500_000,
  parameter int TICK_STEP  = 1_250_000,
  parameter int TICK_MIN   = 2_500_000,
  parameter int LIVES      = 3,
  parameter int MISS_TICKS = 4,
  parameter int SCORE_W    = 4
) (
  input  logic      CLKK,
  input  logic      RESET,
  handball_if.slave bus
);

  logic [2:0]         r_start_sync;   // [0],[1] synchronizer, [2] edge-detect history
  logic [2:0]         r_pulser_sync;
  state_t             r_state;
  logic [2:0]         r_pos;
  logic [SCORE_W-1:0] r_score;
  logic [2:0]         r_lives;
  logic [PER_W-1:0]   r_period;
  logic [7:0]         r_miss_cnt;
  logic [1:0]         r_s;
  logic [7:0]         r_lgin;
  logic               r_over;

  logic               w_start;
  logic               w_pulser;
  logic               w_tick;
  logic               w_tclr;
  act_t               w_act;
  state_t             w_state_d;
  logic [2:0]         w_pos_d;
  logic [SCORE_W-1:0] w_score_d;
  logic [SCORE_W-1:0] w_score_inc;
  logic [2:0]         w_lives_d;
  logic [PER_W-1:0]   w_period_d;
  logic [7:0]         w_miss_d;
  logic [1:0]         w_s;
  logic [7:0]         w_lgin;

  assign w_start     = r_start_sync[1] & ~r_start_sync[2];
  assign w_pulser    = r_pulser_sync[1] & ~r_pulser_sync[2];
  assign w_score_inc = (&r_score) ? r_score : r_score + SCORE_W'(1);

  // The tick block latches the next period so a speed-up applies from the clear at the hit itself
  handball_tick #(
    .W   (PER_W),
    .INIT(TICK_DIV)
  ) u_tick (
    .clk     (CLKK),
    .rst_n   (RESET),
    .i_clr   (w_tclr),
    .i_period(w_period_d),
    .o_tick  (w_tick)
  );

  // Bring the raw buttons into the clock domain and keep one cycle of history for edge detection
  always_ff @(posedge CLKK or negedge RESET) begin
    if (!RESET) begin
      r_start_sync  <= '0;
      r_pulser_sync <= '0;
    end else begin
      r_start_sync  <= {r_start_sync[1:0], bus.START};
      r_pulser_sync <= {r_pulser_sync[1:0], bus.PULSER};
    end
  end

  // State register plus game datapath and registered outputs
  always_ff @(posedge CLKK or negedge RESET) begin
    if (!RESET) begin
      r_state    <= ST_IDLE;
      r_pos      <= '0;
      r_score    <= '0;
      r_lives    <= 3'(LIVES);
      r_period   <= PER_W'(TICK_DIV);
      r_miss_cnt <= '0;
      r_s        <= SH_HOLD;
      r_lgin     <= PAT_BLANK;
      r_over     <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_pos      <= w_pos_d;
      r_score    <= w_score_d;
      r_lives    <= w_lives_d;
      r_period   <= w_period_d;
      r_miss_cnt <= w_miss_d;
      r_s        <= w_s;
      r_lgin     <= w_lgin;
      r_over     <= (w_state_d == ST_OVER);
    end
  end

  // Next state: START overrides everything, PULSER beats a coincident tick
  always_comb begin
    w_act     = ACT_NONE;
    w_state_d = r_state;
    if (w_start) begin
      w_act     = ACT_START;
      w_state_d = ST_OUT;
    end else begin
      unique case (r_state)
        ST_OUT: begin
          if (w_pulser) begin
            w_act     = ACT_MISS;
            w_state_d = (r_lives <= 3'd1) ? ST_OVER : ST_MISS;
          end else if (w_tick) begin
            w_act = (r_pos == 3'd0) ? ACT_SHL : ACT_SHR;
            if (r_pos == 3'd0) w_state_d = ST_BACK;
          end
        end
        ST_BACK: begin
          if (w_pulser && r_pos == 3'd7) begin
            w_act     = ACT_HIT;
            w_state_d = ST_OUT;
          end else if (w_pulser || (w_tick && r_pos == 3'd7)) begin
            w_act     = ACT_MISS;
            w_state_d = (r_lives <= 3'd1) ? ST_OVER : ST_MISS;
          end else if (w_tick) begin
            w_act = ACT_SHL;
          end
        end
        ST_MISS: begin
          if (w_tick) begin
            if (r_miss_cnt == 8'(MISS_TICKS - 1)) begin
              w_act     = ACT_SERVE;
              w_state_d = ST_OUT;
            end else begin
              w_act = ACT_WAIT;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs: translate the chosen action into one LED command and datapath updates
  always_comb begin
    w_s        = SH_HOLD;
    w_lgin     = PAT_BLANK;
    w_pos_d    = r_pos;
    w_score_d  = r_score;
    w_lives_d  = r_lives;
    w_period_d = r_period;
    w_miss_d   = r_miss_cnt;
    w_tclr     = 1'b0;
    unique case (w_act)
      ACT_START: begin
        w_score_d  = '0;
        w_lives_d  = 3'(LIVES);
        w_period_d = PER_W'(TICK_DIV);
        w_tclr     = 1'b1;
        w_s        = SH_LOAD;
        w_lgin     = PAT_SERVE;
        w_pos_d    = 3'd7;
        w_miss_d   = '0;
      end
      ACT_SERVE: begin
        w_s      = SH_LOAD;
        w_lgin   = PAT_SERVE;
        w_pos_d  = 3'd7;
        w_miss_d = '0;
      end
      ACT_SHR: begin
        w_s     = SH_R;
        w_pos_d = r_pos - 3'd1;
      end
      ACT_SHL: begin
        w_s     = SH_L;
        w_pos_d = r_pos + 3'd1;
      end
      ACT_HIT: begin
        w_score_d = w_score_inc;
        w_tclr    = 1'b1;
        // Speed up every 4th hit, never below the floor
        if (w_score_inc[1:0] == 2'b00) begin
          w_period_d = (r_period >= PER_W'(TICK_MIN + TICK_STEP)) ?
                       r_period - PER_W'(TICK_STEP) : PER_W'(TICK_MIN);
        end
      end
      ACT_MISS: begin
        w_lives_d = r_lives - 3'd1;
        w_s       = SH_LOAD;
        w_lgin    = (r_lives <= 3'd1) ? PAT_OVER : PAT_BLANK;
        w_tclr    = 1'b1;
        w_miss_d  = '0;
      end
      ACT_WAIT: begin
        w_miss_d = r_miss_cnt + 8'd1;
      end
      default: ;
    endcase
  end

  assign bus.S          = r_s;
  assign bus.LGIN       = r_lgin;
  assign bus.SCORE      = r_score;
  assign bus.LIVES_LEFT = r_lives;
  assign bus.GAME_OVER  = r_over;

endmodule

// File: doc/handball_ctrl.md
# handball_ctrl

Game sequencer for the electronic handball LED bar. Drives the mode select and parallel-load inputs of the 8-bit bidirectional shift register (Bidshift) that feeds the LEDs. Runs the serve, travel, bounce, hit and miss sequence from the START and PULSER buttons. Also owns the speed tick, the score and the lives; the shift register keeps only the LED pattern.

## Interface
- TICK_DIV, 12_500_000: initial CLKK cycles per ball step.
- TICK_STEP, 1_250_000: period reduction applied every 4th hit.
- TICK_MIN, 2_500_000: floor on the step period.
- LIVES, 3: misses allowed per game (1..7).
- MISS_TICKS, 4: ticks the bar stays blank after a miss before re-serve.
- SCORE_W, 4: score width.
- CLKK  in  1  system clock.
- RESET  in  1  asynchronous, active-low reset.
- START  in  1  raw start button, asynchronous.
- PULSER  in  1  raw player hit button, asynchronous.
- S  out  2  shift register mode: 00 hold, 01 shift toward LSB, 10 shift toward MSB, 11 parallel load.
- LGIN  out  8  parallel-load data; valid when S==11, 0 otherwise.
- SCORE  out  SCORE_W  hits this game; saturates at all-ones.
- LIVES_LEFT  out  3  remaining lives.
- GAME_OVER  out  1  high in OVER state.

## Operation
- START and PULSER each pass through a 2-flop synchronizer and a rising-edge detector. All events below are those 1-cycle edge pulses.
- Internal 3-bit `pos` tracks the ball. The player is at bit 7 and the wall at bit 0.
- A tick generator pulses once every `period` cycles. `period` starts at TICK_DIV.
- Every LED action is a single-cycle S/LGIN command. Otherwise S=00 and LGIN=0.
- States are IDLE, OUT, BACK, MISS and OVER.
- IDLE: waits for START.
- START in any state (highest priority) does the following:
  - SCORE=0, LIVES_LEFT=LIVES, period=TICK_DIV, tick counter cleared.
  - Load 8'h80, pos=7, go to OUT.
- OUT, on tick:
  - pos==0: issue S=10, pos=1, go to BACK (bounce).
  - otherwise: issue S=01, pos−1.
- BACK, on tick:
  - pos==7: miss.
  - otherwise: issue S=10, pos+1.
- PULSER in BACK with pos==7 is a hit:
  - SCORE+1 (saturating).
  - If the new SCORE is a multiple of 4: period = max(period−TICK_STEP, TICK_MIN).
  - Tick counter cleared, go to OUT. No LED command; the next tick shifts right.
- PULSER in OUT, or in BACK with pos!=7, is a foul and is handled as a miss.
- PULSER in IDLE, MISS or OVER is ignored.
- Miss handling:
  - LIVES_LEFT−1, load 8'h00.
  - If LIVES_LEFT becomes 0: load 8'hFF instead and go to OVER.
  - Otherwise go to MISS, with the tick counter cleared.
- MISS: after MISS_TICKS ticks, load 8'h80, pos=7, go to OUT. SCORE and period are kept.
- OVER: S=00, GAME_OVER=1. Only START leaves this state.

## Timing
- Reset values:
  - S=00, LGIN=8'h00, SCORE=0, LIVES_LEFT=LIVES, GAME_OVER=0.
  - State IDLE, pos=0, period=TICK_DIV, tick counter 0, synchronizers 0.
- All outputs are registered.
- Latency from a button edge at the pin to the command on S is 3 CLKK cycles (2 synchronizer stages + 1 register).
- A command is issued on the cycle after the tick (or event) that causes it. The shift register acts on the following edge.
- When PULSER and a tick occur in the same cycle, PULSER is evaluated against the current pos and the tick is discarded. Example: BACK, pos=6, both in the same cycle → foul.
- When START and any other event coincide, START wins.
- At most one command is issued per cycle.
- Reset asserted mid-game returns everything to reset values immediately; no LED command is issued.
- Tick counter: counts 0..period−1 and pulses at period−1. A period change takes effect from the next counter clear.

## Structure
- Shared package `handball_pkg` holds:
  - Mode constants SH_HOLD, SH_R, SH_L, SH_LOAD.
  - The state enum.
  - Patterns PAT_SERVE=8'h80, PAT_BLANK=8'h00, PAT_OVER=8'hFF.
- Sub-module `handball_tick`: programmable-period tick generator with clear input and period input.
- Synchronizers and the FSM stay inline.

## Test plan
All runs use TICK_DIV=4, TICK_STEP=1, TICK_MIN=2, LIVES=3, MISS_TICKS=2.
- Reset then START → one-cycle S=11, LGIN=80; then seven S=01 commands 4 cycles apart; then one S=10 (bounce); then S=10 until pos=7.
- Press PULSER at pos=7 in BACK → SCORE=1, next command S=01 after 4 cycles. After the 4th hit, the spacing becomes 3 cycles. Further hits clamp spacing at 2.
- No PULSER → at the next tick after pos=7 in BACK: S=11, LGIN=00, LIVES_LEFT=2. After 2 ticks: load 80 with SCORE unchanged.
- PULSER during OUT → immediate miss (LGIN=00, LIVES_LEFT decrements). Third miss → LGIN=FF, GAME_OVER=1, PULSER ignored.
- PULSER and tick in the same cycle at BACK pos=6 → foul miss. START coincident with PULSER → new game, SCORE=0.
- RESET pulsed mid-flight → S=00, SCORE=0, LIVES_LEFT=3, state IDLE, no command until START.
